// File: rtl/pipelined_controller_if.sv
// Handshake and decoded-output bundle for the LEGv8 decode stage.
// The slave modport is the decode stage's view. The master modport is the
// view of the fetch side and the consumer side.
interface pipelined_controller_if #(
    parameter int REG_ID_WIDTH    = 5,
    parameter int STALL_CNT_WIDTH = 16
);
    logic                       flush;
    logic [31:0]                instruction;
    logic                       inValid;
    logic                       inReady;
    logic                       outValid;
    logic                       outReady;
    logic [2:0]                 opType;
    logic                       unconditionalBranch;
    logic                       branch;
    logic                       memRead;
    logic                       memToReg;
    logic                       memWrite;
    logic                       aluSRC;
    logic                       regWriteFlag;
    logic [3:0]                 aluControlCode;
    logic [REG_ID_WIDTH-1:0]    readRegister1;
    logic [REG_ID_WIDTH-1:0]    readRegister2;
    logic [REG_ID_WIDTH-1:0]    writeRegister;
    logic [STALL_CNT_WIDTH-1:0] stallCycles;

    modport slave (
        input  flush, instruction, inValid, outReady,
        output inReady, outValid, opType, unconditionalBranch, branch,
               memRead, memToReg, memWrite, aluSRC, regWriteFlag,
               aluControlCode, readRegister1, readRegister2, writeRegister,
               stallCycles
    );

    modport master (
        output flush, instruction, inValid, outReady,
        input  inReady, outValid, opType, unconditionalBranch, branch,
               memRead, memToReg, memWrite, aluSRC, regWriteFlag,
               aluControlCode, readRegister1, readRegister2, writeRegister,
               stallCycles
    );
endinterface

// File: rtl/pipelined_controller.sv
// LEGv8 decode stage: decodes one instruction per cycle into a one-entry
// output register under valid/ready flow control. It stalls consumers of a
// load that has just been issued downstream, and a flush drops the output
// entry together with the load-use window.
module pipelined_controller #(
    parameter int REG_ID_WIDTH    = 5,
    parameter int LOAD_USE_STALL  = 1,
    parameter int ZERO_REG        = 31,
    parameter int STALL_CNT_WIDTH = 16
) (
    input logic                  clock,
    input logic                  resetN,
    pipelined_controller_if.slave bus
);
    localparam logic [2:0] OP_LD = 3'd0;
    localparam logic [2:0] OP_CB = 3'd1;
    localparam logic [2:0] OP_R  = 3'd2;
    localparam logic [2:0] OP_ST = 3'd3;
    localparam logic [2:0] OP_I  = 3'd4;
    localparam logic [2:0] OP_B  = 3'd5;
    localparam logic [2:0] OP_M  = 3'd6;

    localparam logic [REG_ID_WIDTH-1:0] ZR = REG_ID_WIDTH'(ZERO_REG);

    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + STALL_CNT_WIDTH'(1);
    endfunction

    // Stage 0: combinational decode of the incoming instruction
    logic [31:0]             ins;
    logic [2:0]              op_p0;
    logic [3:0]              alu_p0;
    logic [REG_ID_WIDTH-1:0] rs1_p0, rs2_p0, wr_p0;
    logic                    use1_p0, use2_p0;
    logic                    unused_bits;

    assign ins         = bus.instruction;
    assign unused_bits = ^{ins[31], ins[25], ins[21], ins[15:10]};

    // Opcode class, ALU code, register fields and which sources are read
    always_comb begin
        op_p0  = OP_I;
        alu_p0 = 4'b0010;
        if (ins[26])       op_p0 = ins[29] ? OP_CB : OP_B;
        else if (!ins[28]) op_p0 = OP_R;
        else if (ins[23])  op_p0 = OP_M;
        else if (ins[22])  op_p0 = OP_LD;
        else if (ins[27])  op_p0 = OP_ST;
        if (op_p0 == OP_R) begin
            if (ins[30])      alu_p0 = 4'b0110;
            else if (ins[29]) alu_p0 = 4'b0001;
            else if (ins[24]) alu_p0 = 4'b0010;
            else              alu_p0 = 4'b0000;
        end else if (op_p0 == OP_CB) begin
            alu_p0 = 4'b0111;
        end
        rs1_p0  = REG_ID_WIDTH'(ins[9:5]);
        rs2_p0  = (op_p0 == OP_CB || op_p0 == OP_ST) ? REG_ID_WIDTH'(ins[4:0])
                                                     : REG_ID_WIDTH'(ins[20:16]);
        wr_p0   = REG_ID_WIDTH'(ins[4:0]);
        use1_p0 = (op_p0 == OP_R) || (op_p0 == OP_LD) || (op_p0 == OP_ST) ||
                  (op_p0 == OP_I) || (op_p0 == OP_CB);
        use2_p0 = (op_p0 == OP_R) || (op_p0 == OP_ST) || (op_p0 == OP_CB);
    end

    // Stage 1: output entry, load-use window and stall statistics
    logic                       vld_p1;
    logic [2:0]                 op_p1;
    logic [3:0]                 alu_p1;
    logic [REG_ID_WIDTH-1:0]    rs1_p1, rs2_p1, wr_p1;
    logic [2:0]                 cnt_p1;
    logic [REG_ID_WIDTH-1:0]    ld_dest_p1;
    logic [STALL_CNT_WIDTH-1:0] stall_p1;
    logic                       ld_xfer, hit1, hit2, hazard, accept;

    // A source collides with a load leaving this cycle or one still in its window
    assign ld_xfer = vld_p1 & bus.outReady & (op_p1 == OP_LD);
    assign hit1    = (rs1_p0 != ZR) &&
                     ((ld_xfer && rs1_p0 == wr_p1) || (cnt_p1 != 3'd0 && rs1_p0 == ld_dest_p1));
    assign hit2    = (rs2_p0 != ZR) &&
                     ((ld_xfer && rs2_p0 == wr_p1) || (cnt_p1 != 3'd0 && rs2_p0 == ld_dest_p1));
    assign hazard  = (LOAD_USE_STALL != 0) && bus.inValid &&
                     ((use1_p0 && hit1) || (use2_p0 && hit2));

    assign bus.inReady = (!vld_p1 || bus.outReady) && !hazard && !bus.flush;
    assign accept      = bus.inValid && bus.inReady;

    // Output entry: load on accept, hold under backpressure, drop on flush
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            vld_p1 <= 1'b0;
            op_p1  <= 3'd0;
            alu_p1 <= 4'd0;
            rs1_p1 <= '0;
            rs2_p1 <= '0;
            wr_p1  <= '0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            op_p1  <= op_p0;
            alu_p1 <= alu_p0;
            rs1_p1 <= rs1_p0;
            rs2_p1 <= rs2_p0;
            wr_p1  <= wr_p0;
        end else if (bus.outReady) begin
            vld_p1 <= 1'b0;
        end
    end

    // Load-use window: armed when a load leaves, counts down to zero
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_p1     <= 3'd0;
            ld_dest_p1 <= '0;
        end else if (bus.flush) begin
            cnt_p1 <= 3'd0;
        end else if (ld_xfer) begin
            cnt_p1     <= 3'(LOAD_USE_STALL);
            ld_dest_p1 <= wr_p1;
        end else if (cnt_p1 != 3'd0) begin
            cnt_p1 <= cnt_p1 - 3'd1;
        end
    end

    // Saturating count of cycles a valid instruction was held back by a hazard
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)                             stall_p1 <= '0;
        else if (bus.inValid && hazard && !bus.flush) stall_p1 <= sat_inc(stall_p1);
    end

    assign bus.outValid            = vld_p1;
    assign bus.opType              = op_p1;
    assign bus.memRead             = (op_p1 == OP_LD);
    assign bus.memToReg            = (op_p1 == OP_LD);
    assign bus.memWrite            = (op_p1 == OP_ST);
    assign bus.branch              = (op_p1 == OP_CB);
    assign bus.unconditionalBranch = (op_p1 == OP_B);
    assign bus.aluSRC              = (op_p1 == OP_LD) || (op_p1 == OP_ST) || (op_p1 == OP_M);
    assign bus.regWriteFlag        = (op_p1 == OP_R) || (op_p1 == OP_LD) || (op_p1 == OP_M);
    assign bus.aluControlCode      = alu_p1;
    assign bus.readRegister1       = rs1_p1;
    assign bus.readRegister2       = rs2_p1;
    assign bus.writeRegister       = wr_p1;
    assign bus.stallCycles         = stall_p1;
endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for the LEGv8 decode stage: a LOAD_USE_STALL=1 instance
// carries most scenarios, and a LOAD_USE_STALL=0 instance checks that stalls
// are disabled.
module tb_pipelined_controller;
    logic clock = 1'b0;
    logic resetN;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] ADD   = 32'h8B020020; // ADD X0, X1, X2
    localparam logic [31:0] SUB   = 32'hCB020020;
    localparam logic [31:0] ORR   = 32'hAA020020;
    localparam logic [31:0] ANDI  = 32'h8A020020;
    localparam logic [31:0] LDX1  = 32'hF8400041; // LDUR X1, [X2]
    localparam logic [31:0] LDZR  = 32'hF840005F; // LDUR XZR, [X2]
    localparam logic [31:0] ADDZR = 32'h8B0203E0; // ADD X0, XZR, X2
    localparam logic [31:0] CBZ   = 32'hB4000041;
    localparam logic [31:0] STUR  = 32'hF8000041;
    localparam logic [31:0] BR    = 32'h14000010;

    always #5 clock = ~clock;

    pipelined_controller_if #(.REG_ID_WIDTH(5), .STALL_CNT_WIDTH(16)) bus ();
    pipelined_controller_if #(.REG_ID_WIDTH(5), .STALL_CNT_WIDTH(16)) bus0 ();

    pipelined_controller #(.REG_ID_WIDTH(5), .LOAD_USE_STALL(1), .ZERO_REG(31), .STALL_CNT_WIDTH(16))
        dut (.clock(clock), .resetN(resetN), .bus(bus));
    pipelined_controller #(.REG_ID_WIDTH(5), .LOAD_USE_STALL(0), .ZERO_REG(31), .STALL_CNT_WIDTH(16))
        dut0 (.clock(clock), .resetN(resetN), .bus(bus0));

    task automatic drive(input logic [31:0] ins, input logic v, input logic r, input logic f);
        @(negedge clock);
        bus.instruction  = ins; bus.inValid  = v; bus.outReady  = r; bus.flush  = f;
        bus0.instruction = ins; bus0.inValid = v; bus0.outReady = r; bus0.flush = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        resetN = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        resetN = 1'b0;
        #2;
        n_checks++;
        if ({bus.outValid, bus.opType, bus.aluControlCode, bus.writeRegister, bus.stallCycles} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%0b op=%0d alu=%b wr=%0d stalls=%0d required all zero",
                     bus.outValid, bus.opType, bus.aluControlCode, bus.writeRegister, bus.stallCycles);
        end
        resetN = 1'b1;
        drive(ADD, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.inReady !== 1'b1) begin
            n_fail++; $display("FAIL reset_inready: got %0b required 1", bus.inReady);
        end
    endtask

    task automatic test_stream();
        logic [31:0] prog [4];
        logic [3:0]  alu  [4];
        prog = '{ADD, SUB, ORR, ANDI};
        alu  = '{4'b0010, 4'b0110, 4'b0001, 4'b0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(prog[i], 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (bus.inReady !== 1'b1) begin
                n_fail++; $display("FAIL stream_inready[%0d]: got %0b required 1", i, bus.inReady);
            end
            tick();
            n_checks++;
            if ({bus.outValid, bus.opType, bus.aluControlCode, bus.regWriteFlag, bus.readRegister1, bus.readRegister2}
                !== {1'b1, 3'd2, alu[i], 1'b1, 5'd1, 5'd2}) begin
                n_fail++;
                $display("FAIL stream_entry[%0d]: got valid=%0b op=%0d alu=%b rw=%0b rs1=%0d rs2=%0d required 1/2/%b/1/1/2",
                         i, bus.outValid, bus.opType, bus.aluControlCode, bus.regWriteFlag,
                         bus.readRegister1, bus.readRegister2, alu[i]);
            end
        end
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (bus.outValid !== 1'b0) begin
            n_fail++; $display("FAIL stream_drain: got outValid=%0b required 0", bus.outValid);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(LDX1, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({bus.opType, bus.memRead, bus.memToReg, bus.aluSRC, bus.regWriteFlag, bus.memWrite,
             bus.aluControlCode, bus.readRegister1, bus.writeRegister}
            !== {3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 5'd2, 5'd1}) begin
            n_fail++;
            $display("FAIL load_decode: got op=%0d mr=%0b m2r=%0b src=%0b rw=%0b mw=%0b alu=%b rs1=%0d wr=%0d required 0/1/1/1/1/0/0010/2/1",
                     bus.opType, bus.memRead, bus.memToReg, bus.aluSRC, bus.regWriteFlag, bus.memWrite,
                     bus.aluControlCode, bus.readRegister1, bus.writeRegister);
        end
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(ADD, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.inReady !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_stall: got inReady=%0b required 0", bus.inReady);
        end
        tick();
        n_checks++;
        if ({bus.outValid, bus.stallCycles} !== {1'b0, 16'd1}) begin
            n_fail++; $display("FAIL loaduse_count: got valid=%0b stalls=%0d required 0/1", bus.outValid, bus.stallCycles);
        end
        drive(ADD, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.inReady !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_release: got inReady=%0b required 1", bus.inReady);
        end
        tick();
        n_checks++;
        if ({bus.outValid, bus.opType, bus.readRegister1, bus.stallCycles} !== {1'b1, 3'd2, 5'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL loaduse_accept: got valid=%0b op=%0d rs1=%0d stalls=%0d required 1/2/1/1",
                     bus.outValid, bus.opType, bus.readRegister1, bus.stallCycles);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(LDZR, 1'b1, 1'b1, 1'b0);
        tick();
        drive(ADDZR, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.inReady !== 1'b1) begin
            n_fail++; $display("FAIL xzr_inready: got %0b required 1", bus.inReady);
        end
        tick();
        n_checks++;
        if ({bus.outValid, bus.readRegister1, bus.stallCycles} !== {1'b1, 5'd31, 16'd0}) begin
            n_fail++;
            $display("FAIL xzr_accept: got valid=%0b rs1=%0d stalls=%0d required 1/31/0",
                     bus.outValid, bus.readRegister1, bus.stallCycles);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(ADD, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(SUB, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (bus.inReady !== 1'b0) begin
                n_fail++; $display("FAIL bp_inready[%0d]: got %0b required 0", i, bus.inReady);
            end
            tick();
            n_checks++;
            if ({bus.outValid, bus.aluControlCode} !== {1'b1, 4'b0010}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid=%0b alu=%b required 1/0010", i, bus.outValid, bus.aluControlCode);
            end
        end
        drive(SUB, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.inReady !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got inReady=%0b required 1", bus.inReady);
        end
        tick();
        n_checks++;
        if ({bus.outValid, bus.aluControlCode} !== {1'b1, 4'b0110}) begin
            n_fail++; $display("FAIL bp_replace: got valid=%0b alu=%b required 1/0110", bus.outValid, bus.aluControlCode);
        end
    endtask

    task automatic test_branch_store();
        do_reset();
        drive(CBZ, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({bus.opType, bus.branch, bus.unconditionalBranch, bus.aluControlCode, bus.readRegister2, bus.regWriteFlag, bus.aluSRC}
            !== {3'd1, 1'b1, 1'b0, 4'b0111, 5'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL cbz_decode: got op=%0d br=%0b ub=%0b alu=%b rs2=%0d rw=%0b src=%0b required 1/1/0/0111/1/0/0",
                     bus.opType, bus.branch, bus.unconditionalBranch, bus.aluControlCode,
                     bus.readRegister2, bus.regWriteFlag, bus.aluSRC);
        end
        drive(STUR, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({bus.opType, bus.memWrite, bus.aluSRC, bus.readRegister2, bus.memRead, bus.regWriteFlag, bus.aluControlCode}
            !== {3'd3, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL stur_decode: got op=%0d mw=%0b src=%0b rs2=%0d mr=%0b rw=%0b alu=%b required 3/1/1/1/0/0/0010",
                     bus.opType, bus.memWrite, bus.aluSRC, bus.readRegister2, bus.memRead,
                     bus.regWriteFlag, bus.aluControlCode);
        end
        drive(BR, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({bus.opType, bus.unconditionalBranch, bus.branch} !== {3'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b_decode: got op=%0d ub=%0b br=%0b required 5/1/0", bus.opType, bus.unconditionalBranch, bus.branch);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(LDX1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(ADD, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (bus.inReady !== 1'b0) begin
            n_fail++; $display("FAIL flush_inready: got %0b required 0", bus.inReady);
        end
        tick();
        n_checks++;
        if ({bus.outValid, bus.stallCycles} !== {1'b0, 16'd0}) begin
            n_fail++; $display("FAIL flush_clear: got valid=%0b stalls=%0d required 0/0", bus.outValid, bus.stallCycles);
        end
        drive(ADD, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.inReady !== 1'b1) begin
            n_fail++; $display("FAIL flush_window: got inReady=%0b required 1", bus.inReady);
        end
        tick();
        n_checks++;
        if ({bus.outValid, bus.opType, bus.stallCycles} !== {1'b1, 3'd2, 16'd0}) begin
            n_fail++;
            $display("FAIL flush_accept: got valid=%0b op=%0d stalls=%0d required 1/2/0", bus.outValid, bus.opType, bus.stallCycles);
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        drive(LDX1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(ADD, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus0.inReady !== 1'b1) begin
            n_fail++; $display("FAIL nostall_inready: got %0b required 1", bus0.inReady);
        end
        tick();
        n_checks++;
        if ({bus0.outValid, bus0.opType, bus0.stallCycles} !== {1'b1, 3'd2, 16'd0}) begin
            n_fail++;
            $display("FAIL nostall_accept: got valid=%0b op=%0d stalls=%0d required 1/2/0", bus0.outValid, bus0.opType, bus0.stallCycles);
        end
    endtask

    initial begin
        resetN = 1'b1;
        test_reset();
        test_stream();
        test_load_use();
        test_zero_reg();
        test_backpressure();
        test_branch_store();
        test_flush();
        test_no_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
